// File: rtl/par_serial_tx.sv
// Byte-to-bit serializer: every 8th clock loads a payload byte (or the idle symbol)
// and shifts it out MSB first, with byte-start and payload-active markers.
module par_serial_tx #(
    parameter logic [7:0] IDLE_SYM   = 8'hBC,
    parameter int         INIT_BYTES = 4
) (
    input  logic       clk_in,
    input  logic       reset_L,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic       data_out,
    output logic       byte_start,
    output logic       active_out
);

    localparam int ICW = (INIT_BYTES > 1) ? $clog2(INIT_BYTES + 1) : 1;
    localparam logic [ICW-1:0] INIT_LAST = ICW'(INIT_BYTES - 1);

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [2:0]     cnt_q, cnt_d;
    logic [ICW-1:0] init_cnt_q, init_cnt_d;
    logic [6:0]     shift_q, shift_d;
    logic           dout_q, dout_d;
    logic           bstart_q, bstart_d;
    logic           active_q, active_d;
    logic           load_s;
    logic           hs_s;
    logic [7:0]     byte_s;

    assign load_s     = (cnt_q == 3'd7);
    assign ready_out  = reset_L && load_s && (state_q != ST_INIT);
    assign hs_s       = valid_in && ready_out;
    assign byte_s     = hs_s ? data_in : IDLE_SYM;

    assign data_out   = dout_q;
    assign byte_start = bstart_q;
    assign active_out = active_q;

    // Datapath next-state: load a fresh byte on load edges, otherwise shift out the next bit
    always_comb begin
        cnt_d    = cnt_q + 3'd1;
        shift_d  = shift_q;
        dout_d   = dout_q;
        bstart_d = 1'b0;
        active_d = active_q;
        if (load_s) begin
            dout_d   = byte_s[7];
            shift_d  = byte_s[6:0];
            bstart_d = 1'b1;
            active_d = hs_s;
        end else begin
            dout_d  = shift_q[6];
            shift_d = {shift_q[5:0], 1'b0};
        end
    end

    // Control FSM next-state: transitions only happen on load edges
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        case (state_q)
            ST_INIT: begin
                if (load_s) begin
                    init_cnt_d = init_cnt_q + 1'b1;
                    if (init_cnt_q == INIT_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_INIT;
                    end
                end else begin
                    state_d = ST_INIT;
                end
            end
            ST_IDLE, ST_DATA: begin
                if (load_s) begin
                    state_d = hs_s ? ST_DATA : ST_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d    = ST_INIT;
                init_cnt_d = '0;
            end
        endcase
    end

    // State and output registers; reset aborts any byte in flight
    always_ff @(posedge clk_in) begin
        if (!reset_L) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            cnt_q      <= 3'd7;
            shift_q    <= 7'd0;
            dout_q     <= 1'b0;
            bstart_q   <= 1'b0;
            active_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            dout_q     <= dout_d;
            bstart_q   <= bstart_d;
            active_q   <= active_d;
        end
    end

endmodule

// File: tb/tb_par_serial_tx.sv
// Directed and random bench for par_serial_tx, checked against a slot-based reference model.
module tb_par_serial_tx;

    localparam logic [7:0] IDLE = 8'hBC;
    localparam int         NINIT = 4;

    logic       clk_in = 1'b0;
    logic       reset_L = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       valid_in = 1'b0;
    logic       ready_out, data_out, byte_start, active_out;

    int total = 0;
    int bad = 0;

    // Model: k = index of the next edge since reset release; each 8-edge slot carries one byte
    int         k = 0;
    logic [7:0] cur_byte = 8'h00;
    logic       cur_act = 1'b0;

    par_serial_tx dut (
        .clk_in    (clk_in),
        .reset_L   (reset_L),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .data_out  (data_out),
        .byte_start(byte_start),
        .active_out(active_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s at k=%0d: observed=%b expected=%b", tag, k, obs, exp);
        end
    endtask

    // One clock cycle with the given inputs, checking ready before the edge and outputs after
    task automatic cycle(input logic rst_n, input logic v, input logic [7:0] d);
        logic exp_ready;
        int   pos;
        int   slot;
        reset_L  = rst_n;
        valid_in = v;
        data_in  = d;
        @(negedge clk_in);
        pos  = k % 8;
        slot = k / 8;
        exp_ready = rst_n && (pos == 0) && (slot >= NINIT);
        check("ready_out", ready_out, exp_ready);
        @(posedge clk_in);
        #1;
        if (!rst_n) begin
            k = 0;
            cur_byte = 8'h00;
            cur_act  = 1'b0;
            check("rst_data_out", data_out, 1'b0);
            check("rst_byte_start", byte_start, 1'b0);
            check("rst_active_out", active_out, 1'b0);
        end else begin
            if (pos == 0) begin
                cur_act  = exp_ready && v;
                cur_byte = cur_act ? d : IDLE;
            end
            check("data_out", data_out, cur_byte[7 - pos]);
            check("byte_start", byte_start, pos == 0);
            check("active_out", active_out, cur_act);
            k++;
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 8'h00);
    endtask

    // Run idle cycles until the next edge is at position p of a byte slot
    task automatic run_to_pos(input int p);
        for (int i = 0; i < 8 && (k % 8) != p; i++) cycle(1'b1, 1'b0, 8'h00);
    endtask

    // Offer a byte with valid held high for a whole slot starting at the load edge
    task automatic offer_slot(input logic [7:0] d);
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, d);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, $urandom_range(0, 1), 8'($urandom));
    endtask

    initial begin
        do_reset(3);
        // Idle stream after release, INIT then IDLE
        idle_cycles(64);

        // Payload held valid straight from release
        do_reset(1);
        for (int i = 0; i < 48; i++) cycle(1'b1, 1'b1, 8'hA5);
        idle_cycles(8);

        // Back-to-back bytes at consecutive load edges
        run_to_pos(0);
        offer_slot(8'h00);
        offer_slot(8'hFF);
        offer_slot(8'h3C);
        idle_cycles(8);

        // Valid raised three cycles before a load edge
        run_to_pos(5);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 8'h81);
        idle_cycles(12);

        // Reset pulse in the middle of a payload byte
        run_to_pos(0);
        cycle(1'b1, 1'b1, 8'hF0);
        cycle(1'b1, 1'b1, 8'hF0);
        cycle(1'b1, 1'b1, 8'hF0);
        cycle(1'b1, 1'b1, 8'hF0);
        cycle(1'b0, 1'b1, 8'hF0);
        for (int i = 0; i < 40; i++) cycle(1'b1, 1'b1, 8'hF0);
        idle_cycles(8);

        // Single payload followed by idle
        run_to_pos(0);
        cycle(1'b1, 1'b1, 8'h55);
        idle_cycles(16);

        // Random traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                cycle(1'b0, 1'b0, 8'h00);
            end else begin
                cycle(1'b1, $urandom_range(0, 2) != 0, 8'($urandom));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
